// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared constants, FSM state type and row-slicing helpers for the row sequencer
//
// Purpose: common definitions imported by the interface, the sequencer top
//          (mat_row_seq) and the optional column mask (row_col_mask).
// Contents:
//   ROW_W, ELEM_W, N_MAX, ADDR_W, SIZE_MIN  - geometry constants
//   state_t                                 - sequencer FSM states
//   elem_lsb(i)                             - LSB of element i (element 0 is the top byte)
//   size_legal(s)                           - matrix dimension check (SIZE_MIN..N_MAX)

package mat_pkg;

    localparam int ROW_W    = 40;
    localparam int ELEM_W   = 8;
    localparam int N_MAX    = 5;
    localparam int ADDR_W   = 8;
    localparam int SIZE_MIN = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        EXEC    = 3'd3,
        WR      = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Element 0 occupies the most significant byte of the row.
    function automatic int elem_lsb(input int i);
        return (N_MAX - 1 - i) * ELEM_W;
    endfunction

    function automatic logic size_legal(input logic [2:0] s);
        return (s >= 3'(SIZE_MIN)) && (s <= 3'(N_MAX));
    endfunction

endpackage

// File: rtl/mat_row_seq_if.sv
// rtl/mat_row_seq_if.sv - command, memory and negation-stage signal bundle for the row sequencer
//
// Purpose: groups every non-clock/reset signal of mat_row_seq.
// Modports:
//   master - the sequencer: takes command + memory read data + op_result,
//            drives memory address/strobes, op_row/op_rst and status.
//   slave  - the environment (command source, matrix memory, negation stage).
// Signals:
//   start, size[2:0], src_base, dst_base        command
//   busy, done, err                             status
//   mem_addr, mem_rd_en, mem_rd_valid,
//   mem_rd_data, mem_wr_en, mem_wr_data         matrix memory
//   op_row, op_rst, op_result                   negation stage

interface mat_row_seq_if;
    import mat_pkg::*;

    logic              start;
    logic [2:0]        size;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;

    logic              busy;
    logic              done;
    logic              err;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic              mem_rd_valid;
    logic [ROW_W-1:0]  mem_rd_data;
    logic              mem_wr_en;
    logic [ROW_W-1:0]  mem_wr_data;

    logic [ROW_W-1:0]  op_row;
    logic              op_rst;
    logic [ROW_W-1:0]  op_result;

    modport master (
        input  start, size, src_base, dst_base,
        input  mem_rd_valid, mem_rd_data, op_result,
        output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        output op_row, op_rst, busy, done, err
    );

    modport slave (
        output start, size, src_base, dst_base,
        output mem_rd_valid, mem_rd_data, op_result,
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        input  op_row, op_rst, busy, done, err
    );

endinterface

// File: rtl/mat_row_seq_row_col_mask.sv
// rtl/mat_row_seq_row_col_mask.sv - zeroes row elements whose column index is >= the matrix size
//
// Purpose: combinational column mask used by mat_row_seq when COL_MASK_EN is defined.
// Ports:
//   size    in  3      matrix dimension (columns 0..size-1 are kept)
//   row_in  in  ROW_W  row to mask
//   row_out out ROW_W  row with columns >= size forced to 0

module row_col_mask
    import mat_pkg::*;
(
    input  logic [2:0]       size,
    input  logic [ROW_W-1:0] row_in,
    output logic [ROW_W-1:0] row_out
);

    always_comb begin
        row_out = row_in;
        for (int i = 0; i < N_MAX; i++) begin
            if (3'(i) >= size) begin
                row_out[elem_lsb(i) +: ELEM_W] = '0;
            end
        end
    end

endmodule

// File: rtl/mat_row_seq.sv
// rtl/mat_row_seq.sv - row sequencer feeding the row-negation stage and writing results back
//
// Purpose: on an accepted start, reads each of the size rows at src_base+i,
//          presents it to the negation stage for one cycle, captures the
//          result and writes it to dst_base+i; ends with a one-cycle done.
//          Illegal sizes produce a one-cycle err pulse (the cycle after start).
// Build option: COL_MASK_EN - when defined, result columns >= size are zeroed
//          before write-back (row_col_mask); otherwise captured unmodified.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-high reset
//   bus  mat_row_seq_if.master  command / memory / negation-stage signals

module mat_row_seq
    import mat_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mat_row_seq_if.master bus
);

    state_t            state;
    state_t            state_next;

    logic [2:0]        size_q;
    logic [2:0]        row_idx;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ROW_W-1:0]  row_reg;
    logic [ROW_W-1:0]  wr_reg;
    logic              err_q;

    logic              last_row;
    logic [ROW_W-1:0]  result_cap;

    assign last_row = (row_idx == (size_q - 3'd1));

`ifdef COL_MASK_EN
    row_col_mask u_mask (
        .size    (size_q),
        .row_in  (bus.op_result),
        .row_out (result_cap)
    );
`else
    assign result_cap = bus.op_result;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start && size_legal(bus.size)) state_next = RD_REQ;
            RD_REQ:  state_next = RD_WAIT;
            RD_WAIT: if (bus.mem_rd_valid) state_next = EXEC;
            EXEC:    state_next = WR;
            WR:      state_next = last_row ? DONE : RD_REQ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: command latch, row index, row and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q  <= '0;
            row_idx <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            row_reg <= '0;
            wr_reg  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (size_legal(bus.size)) begin
                            size_q  <= bus.size;
                            src_q   <= bus.src_base;
                            dst_q   <= bus.dst_base;
                            row_idx <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RD_WAIT: if (bus.mem_rd_valid) row_reg <= bus.mem_rd_data;
                EXEC:    wr_reg <= result_cap;
                WR:      if (!last_row) row_idx <= row_idx + 3'd1;
                default: ;
            endcase
        end
    end

    // Outputs decode straight from the state so an async reset clears them at once.
    always_comb begin
        bus.mem_addr    = '0;
        bus.mem_rd_en   = 1'b0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = '0;
        bus.op_row      = row_reg;
        bus.op_rst      = 1'b0;
        bus.busy        = (state != IDLE);
        bus.done        = 1'b0;
        bus.err         = err_q;
        case (state)
            IDLE:    bus.op_rst = 1'b1;
            RD_REQ: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = src_q + ADDR_W'(row_idx);
            end
            WR: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_addr    = dst_q + ADDR_W'(row_idx);
                bus.mem_wr_data = wr_reg;
            end
            DONE: begin
                bus.op_rst = 1'b1;
                bus.done   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
